// File: rtl/fft_pkg.sv
// Shared constants and elaboration-time helpers for the SDF FFT stage controllers.
// Cosine table entries are computed with integer fixed point so any elaborator can fold them.
package fft_pkg;

   localparam logic [1:0] ST_PRIME  = 2'd0;
   localparam logic [1:0] ST_BFLY   = 2'd1;
   localparam logic [1:0] ST_ROTATE = 2'd2;

   localparam longint PI_Q30 = 64'sd3373259426;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Entry i of the quarter-wave table: round(cos(2*pi*i/n_points) * 2^tw_frac).
   // Taylor series in Q30; i <= n_points/4 keeps the angle within [0, pi/2].
   function automatic longint cos_entry(input int n_points, input int tw_width,
                                        input int tw_frac, input int i);
      longint x;
      longint x2;
      longint term;
      longint acc;
      longint r;
      longint max_pos;
      x    = (2 * PI_Q30 * i) / n_points;
      x2   = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      acc  = term;
      for (int k = 1; k <= 12; k++) begin
         term = -((term * x2) >>> 30) / ((2 * k - 1) * (2 * k));
         acc  = acc + term;
      end
      r       = (acc * (64'sd1 <<< tw_frac) + (64'sd1 <<< 29)) >>> 30;
      max_pos = (64'sd1 <<< (tw_width - 1)) - 1;
      if (r > max_pos) r = max_pos;
      return r;
   endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: folds exponent e in [0, N/2) onto a quarter-wave
// cosine table and returns W_N^e = cos - j*sin.
module fft_twiddle_rom
   import fft_pkg::*;
#(
   parameter int N_POINTS = 64,
   parameter int TW_WIDTH = 24,
   parameter int TW_FRAC  = 8,
   localparam int IDX_W   = clog2(N_POINTS) - 1
) (
   input  logic [IDX_W-1:0]    e,
   output logic [TW_WIDTH-1:0] w_r,
   output logic [TW_WIDTH-1:0] w_i
);

   localparam int QTR = N_POINTS / 4;

   logic [TW_WIDTH-1:0] cos_tab [0:QTR];
   logic [IDX_W-1:0]    idx_r;
   logic [IDX_W-1:0]    idx_i;
   logic                neg_r;

   for (genvar gi = 0; gi <= QTR; gi++) begin : g_tab
      localparam logic [TW_WIDTH-1:0] C_VAL =
         TW_WIDTH'(cos_entry(N_POINTS, TW_WIDTH, TW_FRAC, gi));
      assign cos_tab[gi] = C_VAL;
   end

   always_comb begin
      idx_r = e;
      idx_i = IDX_W'(QTR) - e;
      neg_r = 1'b0;
      if (e > IDX_W'(QTR)) begin
         // N/2 - e wraps correctly in IDX_W bits since N/2 = 2^IDX_W
         idx_r = IDX_W'(2 * QTR) - e;
         idx_i = e - IDX_W'(QTR);
         neg_r = 1'b1;
      end
   end

   assign w_r = neg_r ? -cos_tab[idx_r] : cos_tab[idx_r];
   assign w_i = -cos_tab[idx_i];

endmodule

// File: rtl/fft_twiddle_seq.sv
// Per-stage sample counter, phase classifier and registered twiddle source
// for one radix-2 SDF DIF FFT stage.
module fft_twiddle_seq
   import fft_pkg::*;
#(
   parameter int N_POINTS = 64,
   parameter int STAGE    = 0,
   parameter int TW_WIDTH = 24,
   parameter int TW_FRAC  = 8,
   localparam int IDX_W   = clog2(N_POINTS) - 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                flush,
   output logic                out_valid,
   output logic [1:0]          state,
   output logic [TW_WIDTH-1:0] w_r,
   output logic [TW_WIDTH-1:0] w_i,
   output logic [IDX_W-1:0]    tw_idx,
   output logic                frame_last
);

   localparam int CNT_W = clog2(N_POINTS) - STAGE;
   localparam int SPAN  = N_POINTS >> STAGE;
   localparam int HALF  = SPAN / 2;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SPAN - 1);
   localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(HALF);
   localparam logic [TW_WIDTH-1:0] W_ONE    = TW_WIDTH'(2 ** TW_FRAC);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                primed_q, primed_d;
   logic                out_valid_q, out_valid_d;
   logic [1:0]          state_q, state_d;
   logic [TW_WIDTH-1:0] w_r_q, w_r_d;
   logic [TW_WIDTH-1:0] w_i_q, w_i_d;
   logic [IDX_W-1:0]    tw_idx_q, tw_idx_d;
   logic                frame_last_q, frame_last_d;

   logic [1:0]          phase;
   logic [IDX_W-1:0]    e_sel;
   logic [TW_WIDTH-1:0] rom_w_r;
   logic [TW_WIDTH-1:0] rom_w_i;

   // Only the lower half of a primed span rotates; everything else uses W^0.
   always_comb begin
      phase = ST_BFLY;
      e_sel = '0;
      if (cnt_q < CNT_HALF) begin
         if (primed_q) begin
            phase = ST_ROTATE;
            e_sel = IDX_W'(cnt_q) << STAGE;
         end else begin
            phase = ST_PRIME;
         end
      end
   end

   fft_twiddle_rom #(
      .N_POINTS (N_POINTS),
      .TW_WIDTH (TW_WIDTH),
      .TW_FRAC  (TW_FRAC)
   ) u_rom (
      .e   (e_sel),
      .w_r (rom_w_r),
      .w_i (rom_w_i)
   );

   always_comb begin
      cnt_d        = cnt_q;
      primed_d     = primed_q;
      out_valid_d  = 1'b0;
      frame_last_d = 1'b0;
      state_d      = state_q;
      w_r_d        = w_r_q;
      w_i_d        = w_i_q;
      tw_idx_d     = tw_idx_q;
      if (flush) begin
         cnt_d    = '0;
         primed_d = 1'b0;
      end else if (in_valid) begin
         cnt_d       = cnt_q + CNT_W'(1);
         out_valid_d = 1'b1;
         state_d     = phase;
         w_r_d       = rom_w_r;
         w_i_d       = rom_w_i;
         tw_idx_d    = e_sel;
         if (cnt_q == CNT_LAST) begin
            primed_d     = 1'b1;
            frame_last_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         primed_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         state_q      <= ST_PRIME;
         w_r_q        <= W_ONE;
         w_i_q        <= '0;
         tw_idx_q     <= '0;
         frame_last_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         primed_q     <= primed_d;
         out_valid_q  <= out_valid_d;
         state_q      <= state_d;
         w_r_q        <= w_r_d;
         w_i_q        <= w_i_d;
         tw_idx_q     <= tw_idx_d;
         frame_last_q <= frame_last_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign state      = state_q;
   assign w_r        = w_r_q;
   assign w_i        = w_i_q;
   assign tw_idx     = tw_idx_q;
   assign frame_last = frame_last_q;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Bench for fft_twiddle_seq: four configurations driven in lockstep and compared
// against a cycle-level behavioural model using real-valued cos/sin.
module tb_fft_twiddle_seq;

   localparam int NDUT = 4;
   localparam int M_N     [NDUT] = '{8, 8, 8, 64};
   localparam int M_STAGE [NDUT] = '{0, 1, 2, 1};
   localparam real PI_R = 3.14159265358979323846;

   localparam int S1_STATE [16] = '{0,0,0,0,1,1,1,1,2,2,2,2,1,1,1,1};
   localparam int S3_STATE [8]  = '{0,0,1,1,2,2,1,1};
   localparam logic [23:0] S2_WR [4] = '{24'h000100, 24'h0000B5, 24'h000000, 24'hFFFF4B};
   localparam logic [23:0] S2_WI [4] = '{24'h000000, 24'hFFFF4B, 24'hFFFF00, 24'hFFFF4B};

   logic clk = 1'b0;
   logic rst, in_valid, flush;

   logic        a_valid, b_valid, c_valid, d_valid;
   logic [1:0]  a_state, b_state, c_state, d_state;
   logic [23:0] a_wr, a_wi, b_wr, b_wi, c_wr, c_wi, d_wr, d_wi;
   logic [1:0]  a_idx, b_idx, c_idx;
   logic [4:0]  d_idx;
   logic        a_fl, b_fl, c_fl, d_fl;

   logic        obs_valid [NDUT];
   logic [1:0]  obs_state [NDUT];
   logic [23:0] obs_wr    [NDUT];
   logic [23:0] obs_wi    [NDUT];
   logic [7:0]  obs_idx   [NDUT];
   logic        obs_fl    [NDUT];

   int m_cnt [NDUT];
   int m_primed [NDUT];
   int exp_valid [NDUT];
   int exp_state [NDUT];
   int exp_wr [NDUT];
   int exp_wi [NDUT];
   int exp_idx [NDUT];
   int exp_fl [NDUT];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fft_twiddle_seq #(.N_POINTS(8), .STAGE(0), .TW_WIDTH(24), .TW_FRAC(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .out_valid(a_valid), .state(a_state), .w_r(a_wr), .w_i(a_wi),
      .tw_idx(a_idx), .frame_last(a_fl));
   fft_twiddle_seq #(.N_POINTS(8), .STAGE(1), .TW_WIDTH(24), .TW_FRAC(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .out_valid(b_valid), .state(b_state), .w_r(b_wr), .w_i(b_wi),
      .tw_idx(b_idx), .frame_last(b_fl));
   fft_twiddle_seq #(.N_POINTS(8), .STAGE(2), .TW_WIDTH(24), .TW_FRAC(8)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .out_valid(c_valid), .state(c_state), .w_r(c_wr), .w_i(c_wi),
      .tw_idx(c_idx), .frame_last(c_fl));
   fft_twiddle_seq #(.N_POINTS(64), .STAGE(1), .TW_WIDTH(24), .TW_FRAC(8)) dut_d (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .out_valid(d_valid), .state(d_state), .w_r(d_wr), .w_i(d_wi),
      .tw_idx(d_idx), .frame_last(d_fl));

   assign obs_valid[0] = a_valid;  assign obs_valid[1] = b_valid;
   assign obs_valid[2] = c_valid;  assign obs_valid[3] = d_valid;
   assign obs_state[0] = a_state;  assign obs_state[1] = b_state;
   assign obs_state[2] = c_state;  assign obs_state[3] = d_state;
   assign obs_wr[0] = a_wr;  assign obs_wr[1] = b_wr;  assign obs_wr[2] = c_wr;  assign obs_wr[3] = d_wr;
   assign obs_wi[0] = a_wi;  assign obs_wi[1] = b_wi;  assign obs_wi[2] = c_wi;  assign obs_wi[3] = d_wi;
   assign obs_idx[0] = 8'(a_idx);  assign obs_idx[1] = 8'(b_idx);
   assign obs_idx[2] = 8'(c_idx);  assign obs_idx[3] = 8'(d_idx);
   assign obs_fl[0] = a_fl;  assign obs_fl[1] = b_fl;  assign obs_fl[2] = c_fl;  assign obs_fl[3] = d_fl;

   function automatic int rnd(input real r);
      if (r >= 0.0) return int'($floor(r + 0.5));
      return -int'($floor(-r + 0.5));
   endfunction

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d t=%0t: observed=%0h expected=%0h", tag, k, $time, obs, exp);
      end
   endtask

   // Reference: span/half-span counting and W = exp(-j*2*pi*e/N) evaluated directly.
   task automatic model(input logic v, input logic f, input logic r);
      for (int k = 0; k < NDUT; k++) begin
         int  span;
         int  e;
         real th;
         span = M_N[k] >> M_STAGE[k];
         if (r) begin
            m_cnt[k] = 0;  m_primed[k] = 0;
            exp_valid[k] = 0;  exp_state[k] = 0;  exp_wr[k] = 256;
            exp_wi[k] = 0;  exp_idx[k] = 0;  exp_fl[k] = 0;
         end else if (f) begin
            m_cnt[k] = 0;  m_primed[k] = 0;
            exp_valid[k] = 0;  exp_fl[k] = 0;
         end else if (v) begin
            e = 0;
            if (m_cnt[k] >= span / 2) exp_state[k] = 1;
            else if (m_primed[k] == 0) exp_state[k] = 0;
            else begin
               exp_state[k] = 2;
               e = m_cnt[k] * (M_N[k] / span);
            end
            th = 2.0 * PI_R * real'(e) / real'(M_N[k]);
            exp_wr[k]    = rnd($cos(th) * 256.0);
            exp_wi[k]    = rnd(-$sin(th) * 256.0);
            exp_idx[k]   = e;
            exp_fl[k]    = (m_cnt[k] == span - 1) ? 1 : 0;
            exp_valid[k] = 1;
            m_cnt[k]++;
            if (m_cnt[k] == span) begin
               m_cnt[k] = 0;
               m_primed[k] = 1;
            end
         end else begin
            exp_valid[k] = 0;  exp_fl[k] = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NDUT; k++) begin
         check("out_valid", k, 32'(obs_valid[k]), 32'(exp_valid[k]));
         check("state", k, 32'(obs_state[k]), 32'(exp_state[k]));
         check("w_r", k, {8'h0, obs_wr[k]}, {8'h0, 24'(exp_wr[k])});
         check("w_i", k, {8'h0, obs_wi[k]}, {8'h0, 24'(exp_wi[k])});
         check("tw_idx", k, 32'(obs_idx[k]), 32'(exp_idx[k]));
         check("frame_last", k, 32'(obs_fl[k]), 32'(exp_fl[k]));
      end
   endtask

   task automatic step(input logic v, input logic f, input logic r);
      in_valid = v;  flush = f;  rst = r;
      @(posedge clk);
      model(v, f, r);
      #1;
      check_all();
   endtask

   initial begin
      // reset state
      step(0, 0, 1);
      step(0, 0, 1);
      check("reset_w_r", 0, {8'h0, a_wr}, 32'h100);
      check("reset_valid", 0, 32'(a_valid), 32'd0);

      // continuous stream: phase sequence, frame_last and rotate twiddles
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0);
         check("s1_state", 0, 32'(a_state), 32'(S1_STATE[i]));
         check("s1_last", 0, 32'(a_fl), (i == 7 || i == 15) ? 32'd1 : 32'd0);
         if (i >= 8 && i < 12) begin
            check("s2_w_r", 0, {8'h0, a_wr}, {8'h0, S2_WR[i - 8]});
            check("s2_w_i", 0, {8'h0, a_wi}, {8'h0, S2_WI[i - 8]});
            check("s2_idx", 0, 32'(a_idx), 32'(i - 8));
         end
         if (i < 8) check("s3_state", 1, 32'(b_state), 32'(S3_STATE[i]));
         if (i == 5) begin
            check("s3_w_r", 1, {8'h0, b_wr}, 32'h0);
            check("s3_w_i", 1, {8'h0, b_wi}, 32'hFFFF00);
            check("s3_idx", 1, 32'(b_idx), 32'd2);
         end
      end

      // gapped input: outputs hold through idle cycles
      step(0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0);
         check("gap_state", 0, 32'(a_state), 32'(S1_STATE[i]));
         step(0, 0, 0);
         check("gap_hold", 0, 32'(a_state), 32'(S1_STATE[i]));
         check("gap_valid", 0, 32'(a_valid), 32'd0);
      end

      // flush together with a sample re-primes the stage
      step(0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 0, 0);
      step(1, 1, 0);
      check("flush_valid", 0, 32'(a_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0);
         check("flush_restart", 0, 32'(a_state), 32'(S1_STATE[i]));
      end

      // reset wins over flush and in_valid mid-rotate
      step(0, 0, 1);
      for (int i = 0; i < 9; i++) step(1, 0, 0);
      step(1, 1, 1);
      check("rst_w_r", 0, {8'h0, a_wr}, 32'h100);
      check("rst_state", 0, 32'(a_state), 32'd0);
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0);
         check("rst_restart", 0, 32'(a_state), 32'(S1_STATE[i]));
      end

      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 250) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_twiddle_seq.md
Name: fft_twiddle_seq

Overview:
Parametrised per-stage control and twiddle generator for a radix-2 single-path delay-feedback (SDF) DIF FFT stage.
- Counts accepted samples within a butterfly span and classifies each sample into a phase code (prime / butterfly / rotate) for the stage datapath.
- Supplies the matching complex twiddle factor from a quarter-wave cosine table.
- Sits beside each FFT stage datapath; one instance per stage, selected by STAGE.

Parameters:
N_POINTS, 64, FFT size; power of two, >= 8.
STAGE, 0, stage index, 0 .. log2(N_POINTS)-1; span L = N_POINTS >> STAGE, half span H = L/2.
TW_WIDTH, 24, twiddle word width, two's complement.
TW_FRAC, 8, fractional bits of twiddle; 1.0 = 2^TW_FRAC.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  one sample accepted this cycle.
flush  in  1  synchronous re-prime; clears counter and primed flag.
out_valid  out  1  state/twiddle/tw_idx valid for the sample accepted one cycle earlier.
state  out  2  0 = PRIME, 1 = BFLY, 2 = ROTATE; 3 is never driven.
w_r  out  TW_WIDTH  twiddle real part.
w_i  out  TW_WIDTH  twiddle imaginary part.
tw_idx  out  log2(N_POINTS)-1  exponent e of W_N^e used for w_r/w_i.
frame_last  out  1  pulses with the last sample of a span (cnt = L-1).

Behaviour:
- Reset (rst = 1 at a clock edge):
  - cnt = 0, primed = 0.
  - out_valid = 0, state = 0, w_r = 2^TW_FRAC, w_i = 0, tw_idx = 0, frame_last = 0.
- Priority: rst > flush > in_valid.
  - flush clears cnt and primed and forces out_valid = 0.
  - An in_valid in the same cycle as flush is discarded.
- Counter: cnt (log2 L bits) increments on each accepted sample and wraps L-1 -> 0. primed is set on the first wrap and stays set until rst or flush.
- Phase code, per accepted sample at count cnt:
  - cnt >= H -> BFLY.
  - cnt < H and primed = 0 -> PRIME.
  - cnt < H and primed = 1 -> ROTATE.
- Exponent: e = cnt * 2^STAGE, valid for 0 <= cnt < H, so e is in [0, N/2). In PRIME and BFLY, e = 0.
- Twiddle: W = cos(2*pi*e/N) - j*sin(2*pi*e/N), from table C[i] = round(cos(2*pi*i/N) * 2^TW_FRAC), i = 0..N/4.
  - e <= N/4: w_r = C[e], w_i = -C[N/4-e].
  - e > N/4: w_r = -C[N/2-e], w_i = -C[e-N/4].
  - PRIME/BFLY: w_r = C[0], w_i = 0.
- Latency: exactly 1 cycle from accepted in_valid to out_valid and its outputs. All outputs are registered.
- Idle cycles (in_valid = 0):
  - out_valid = 0 and frame_last = 0.
  - state, w_r, w_i and tw_idx hold their last values.
  - cnt holds.
- Last stage (L = 2, H = 1): only e = 0 occurs; the twiddle is always 1 + j0.
- Back-to-back in_valid is supported at full rate, with no bubbles.

Decomposition:
- Package fft_pkg holds:
  - phase constants ST_PRIME = 2'd0, ST_BFLY = 2'd1, ST_ROTATE = 2'd2;
  - a clog2 function;
  - the constant function building the quarter-wave cosine table from N_POINTS, TW_WIDTH and TW_FRAC.
- Sub-module fft_twiddle_rom (parameters N_POINTS, TW_WIDTH, TW_FRAC):
  - maps e to (w_r, w_i) by quadrant folding;
  - is combinational lookup, registered by the parent.
- The parent holds the counter, primed flag, phase logic and output registers.

Test Plan:
1. N=8, STAGE=0, TW_FRAC=8; rst then 16 continuous in_valid. Expect on the next cycle for each sample:
   - state 0,0,0,0,1,1,1,1,2,2,2,2,1,1,1,1;
   - frame_last on samples 7 and 15.
2. Same configuration, ROTATE samples 8..11. Expect (w_r, w_i) as 24-bit two's complement:
   - (0x000100, 0x000000), (0x0000B5, 0xFFFF4B), (0x000000, 0xFFFF00), (0xFFFF4B, 0xFFFF4B);
   - tw_idx 0, 1, 2, 3.
3. N=8, STAGE=1; 8 samples. Expect:
   - state 0,0,1,1,2,2,1,1;
   - ROTATE twiddles (0x000100, 0), then (0, 0xFFFF00) with tw_idx 2.
4. Gapped input: in_valid toggling 1,0,1,0. Expect:
   - out_valid mirrors the input delayed by 1 cycle;
   - state and twiddle hold through gaps;
   - the sequence is identical to scenario 1.
5. flush asserted with in_valid at sample 10 of scenario 1. Expect:
   - out_valid = 0 next cycle;
   - the following samples restart as PRIME with cnt = 0.
6. rst asserted mid-ROTATE together with flush and in_valid. Expect:
   - all outputs at their reset values next cycle;
   - the subsequent sequence matches scenario 1 from the start.
